regfile_write_arbiter: RTL and testbench

//   Owns the single write port (WriteRegister/WriteData/RegWrite) of the 32x32 regfile.

---
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the 32-entry regfile.
// The master side drives requests and observes the regfile write; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic [ADDR_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  write_register, write_data, reg_write
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output write_register, write_data, reg_write
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the regfile write port: round-robin arbitration of two requesters, zero-fill of
// registers 1..NREG-1 after reset or on request, and suppression of writes to register 0.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear_req,
    output logic                           o_busy,
    regfile_write_arbiter_if.slave         io_wr
);
    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = '1;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state,          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt,        w_clr_cnt_nxt;
    logic                  r_rr_ptr,         w_rr_ptr_nxt;
    logic                  r_reg_write,      w_reg_write_nxt;
    logic [ADDR_WIDTH-1:0] r_write_register, w_write_register_nxt;
    logic [DATA_WIDTH-1:0] r_write_data,     w_write_data_nxt;
    logic                  w_grant0;
    logic                  w_grant1;

    // The output registers double as the pending-write register: they are loaded with
    // whatever the port must present in the following cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
        w_state_nxt          = r_state;
        w_clr_cnt_nxt        = r_clr_cnt;
        w_rr_ptr_nxt         = r_rr_ptr;
        w_reg_write_nxt      = 1'b0;
        w_write_register_nxt = r_write_register;
        w_write_data_nxt     = r_write_data;
        w_grant0             = 1'b0;
        w_grant1             = 1'b0;

        unique case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == LAST_REG) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_clr_cnt_nxt        = r_clr_cnt + 1'b1;
                    w_reg_write_nxt      = 1'b1;
                    w_write_register_nxt = r_clr_cnt + 1'b1;
                    w_write_data_nxt     = '0;
                end
            end
            ST_ARB: begin
                if (i_clear_req) begin
                    w_state_nxt          = ST_CLEAR;
                    w_clr_cnt_nxt        = FIRST_REG;
                    w_reg_write_nxt      = 1'b1;
                    w_write_register_nxt = FIRST_REG;
                    w_write_data_nxt     = '0;
                end else begin
                    w_grant0 = io_wr.req0_valid && (!io_wr.req1_valid || !r_rr_ptr);
                    w_grant1 = io_wr.req1_valid && (!io_wr.req0_valid ||  r_rr_ptr);
                    if (w_grant0) begin
                        w_rr_ptr_nxt         = 1'b1;
                        w_reg_write_nxt      = (io_wr.req0_addr != '0);
                        w_write_register_nxt = io_wr.req0_addr;
                        w_write_data_nxt     = io_wr.req0_data;
                    end else if (w_grant1) begin
                        w_rr_ptr_nxt         = 1'b0;
                        w_reg_write_nxt      = (io_wr.req1_addr != '0);
                        w_write_register_nxt = io_wr.req1_addr;
                        w_write_data_nxt     = io_wr.req1_data;
                    end
                end
            end
            default: ;
        endcase
    end

    // With CLEAR_ON_RESET the first post-reset cycle already drives the clear of register 1.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            r_state          <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            r_clr_cnt        <= FIRST_REG;
            r_rr_ptr         <= 1'b0;
            r_reg_write      <= CLEAR_ON_RESET;
            r_write_register <= CLEAR_ON_RESET ? FIRST_REG : '0;
            r_write_data     <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_clr_cnt        <= w_clr_cnt_nxt;
            r_rr_ptr         <= w_rr_ptr_nxt;
            r_reg_write      <= w_reg_write_nxt;
            r_write_register <= w_write_register_nxt;
            r_write_data     <= w_write_data_nxt;
        end
    end

    assign io_wr.req0_ready     = w_grant0;
    assign io_wr.req1_ready     = w_grant1;
    assign io_wr.reg_write      = r_reg_write;
    assign io_wr.write_register = r_write_register;
    assign io_wr.write_data     = r_write_data;
    assign o_busy               = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts grants and queues the
// expected regfile writes, which are popped and compared when the write port issues them.
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst, clr, busy;
    logic rst_nc, clr_nc, busy_nc;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wr_if ();
    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wr_if_nc ();

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_clear_req (clr),
        .o_busy      (busy),
        .io_wr       (wr_if.slave)
    );

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .i_clk       (clk),
        .i_reset     (rst_nc),
        .i_clear_req (clr_nc),
        .o_busy      (busy_nc),
        .io_wr       (wr_if_nc.slave)
    );

    // Regfile as seen by the design; register 0 is deliberately not protected here.
    logic [DW-1:0] rf [32];
    always @(posedge clk)
        if (wr_if.reg_write === 1'b1) rf[wr_if.write_register] <= wr_if.write_data;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t sb [$];
    logic [DW-1:0] m_rf [32];
    bit  m_valid = 1'b0;
    bit  m_clear = 1'b0;
    int  m_clr   = 1;
    bit  m_ptr   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), rf[i], m_rf[i]);
    endtask

    // One clock of stimulus: drive, compare the current cycle, then advance the model at the edge.
    task automatic cycle(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit c, input bit r);
        bit  g0 = 1'b0;
        bit  g1 = 1'b0;
        wr_t e;
        wr_if.req0_valid = v0; wr_if.req0_addr = a0; wr_if.req0_data = d0;
        wr_if.req1_valid = v1; wr_if.req1_addr = a1; wr_if.req1_data = d1;
        clr = c;
        rst = r;
        #1;
        if (m_valid) begin
            check("busy", busy, m_clear);
            if (m_clear) begin
                check("clr_we", wr_if.reg_write, 1);
                check("clr_reg", wr_if.write_register, m_clr);
                check("clr_data", wr_if.write_data, 0);
                check("clr_rdy0", wr_if.req0_ready, 0);
                check("clr_rdy1", wr_if.req1_ready, 0);
                m_rf[m_clr] = '0;
            end else begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("wr_we", wr_if.reg_write, e.addr != '0);
                    if (e.addr != '0) begin
                        check("wr_reg", wr_if.write_register, e.addr);
                        check("wr_data", wr_if.write_data, e.data);
                        m_rf[e.addr] = e.data;
                    end
                end else begin
                    check("idle_we", wr_if.reg_write, 0);
                end
                g0 = !c && v0 && (!v1 || !m_ptr);
                g1 = !c && v1 && (!v0 ||  m_ptr);
                check("rdy0", wr_if.req0_ready, g0);
                check("rdy1", wr_if.req1_ready, g1);
            end
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1; m_clear = 1'b1; m_clr = 1; m_ptr = 1'b0;
            sb.delete();
        end else if (m_clear) begin
            if (m_clr == 31) m_clear = 1'b0;
            else m_clr++;
        end else if (c) begin
            m_clear = 1'b1; m_clr = 1;
        end else if (g0) begin
            e.addr = a0; e.data = d0; sb.push_back(e); m_ptr = 1'b1;
        end else if (g1) begin
            e.addr = a1; e.data = d1; sb.push_back(e); m_ptr = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]   = (i == 0) ? '0 : 32'hdead_0000 + i;
            m_rf[i] = rf[i];
        end
        rst_nc = 1'b1; clr_nc = 1'b0;
        wr_if_nc.req0_valid = 1'b0; wr_if_nc.req0_addr = '0; wr_if_nc.req0_data = '0;
        wr_if_nc.req1_valid = 1'b0; wr_if_nc.req1_addr = '0; wr_if_nc.req1_data = '0;
        @(negedge clk);

        // Reset then the 31-cycle zero-fill
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(32);
        check_all_regs("after_clear");

        // Single write from requester 0
        cycle(1, 2, 42, 0, 0, 0, 0, 0);
        idle(2);
        check("rf2", rf[2], 42);

        // Lone requester 1, then both held valid: alternation from requester 0
        cycle(0, 0, 0, 1, 3, 55, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 8, 10, 1, 31, 713, 0, 0);
        idle(2);
        check("rf8", rf[8], 10);
        check("rf31", rf[31], 713);
        check_all_regs("after_rr");

        // Register 0 is accepted but never written
        cycle(0, 0, 0, 1, 0, 404, 0, 0);
        idle(2);
        check("rf0", rf[0], 0);

        // Random traffic on both requesters
        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom, 0, 0);
        idle(2);
        check_all_regs("after_rand");

        // Clear request right after an accept, with both requesters valid
        cycle(1, 8, 77, 0, 0, 0, 0, 0);
        cycle(1, 9, 99, 1, 10, 100, 1, 0);
        idle(32);
        check("rf8_cleared", rf[8], 0);
        check_all_regs("after_clrreq");

        // Reset in the middle of a clear (ClrCnt=10) restarts from register 1
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(9);
        check("mid_clr_cnt", m_clr, 10);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(32);

        // Reset the cycle after an accept: no stale write follows
        cycle(1, 4, 44, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(32);
        check_all_regs("after_rst");

        // Instance without clear-on-reset
        rst_nc = 1'b0;
        #1;
        check("nc_busy", busy_nc, 0);
        check("nc_we", wr_if_nc.reg_write, 0);
        check("nc_reg", wr_if_nc.write_register, 0);
        check("nc_data", wr_if_nc.write_data, 0);
        wr_if_nc.req0_valid = 1'b1; wr_if_nc.req0_addr = 5; wr_if_nc.req0_data = 77;
        #1;
        check("nc_rdy0", wr_if_nc.req0_ready, 1);
        @(posedge clk); @(negedge clk);
        wr_if_nc.req0_addr = 6; wr_if_nc.req0_data = 88;
        #1;
        check("nc_wr_we", wr_if_nc.reg_write, 1);
        check("nc_wr_reg", wr_if_nc.write_register, 5);
        check("nc_wr_data", wr_if_nc.write_data, 77);
        @(posedge clk); @(negedge clk);
        wr_if_nc.req0_valid = 1'b0;
        rst_nc = 1'b1;
        #1;
        check("nc_wr2_we", wr_if_nc.reg_write, 1);
        check("nc_wr2_reg", wr_if_nc.write_register, 6);
        @(posedge clk); @(negedge clk);
        rst_nc = 1'b0;
        #1;
        check("nc_rst_we", wr_if_nc.reg_write, 0);
        check("nc_rst_busy", busy_nc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
